// File: rtl/ddr_sram_access_arbiter_if.sv
// Bundle of client request/acknowledge signals and the DDR_SRAM strobe/data signals
// seen by the access arbiter. The arbiter uses the master view; clients and the SRAM side use slave.
interface ddr_sram_access_arbiter_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
);
   logic [1:0]            req;
   logic [1:0]            wr;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] wdata0;
   logic [DATA_WIDTH-1:0] wdata1;
   logic [1:0]            ack;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  busy;
   logic [ADDR_WIDTH-1:0] sram_address;
   logic                  sram_enable;
   logic                  sram_read;
   logic                  sram_write;
   logic [DATA_WIDTH-1:0] sram_data_out;
   logic                  sram_data_oe;
   logic [DATA_WIDTH-1:0] sram_data_in;

   modport master (
      input  req, wr, addr0, addr1, wdata0, wdata1, sram_data_in,
      output ack, rdata, busy, sram_address, sram_enable, sram_read, sram_write,
             sram_data_out, sram_data_oe
   );

   modport slave (
      output req, wr, addr0, addr1, wdata0, wdata1, sram_data_in,
      input  ack, rdata, busy, sram_address, sram_enable, sram_read, sram_write,
             sram_data_out, sram_data_oe
   );
endinterface

// File: rtl/ddr_sram_access_arbiter.sv
// Two-client access arbiter and strobe sequencer for the DDR_SRAM macro; all outputs registered.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking, otherwise client 0 has fixed priority.
module ddr_sram_access_arbiter #(
   parameter int ADDR_WIDTH    = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int ACCESS_CYCLES = 2
) (
   input logic                      clk,
   input logic                      rst_n,
   ddr_sram_access_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

   state_t                state, state_nxt;
   logic [3:0]            cnt, cnt_nxt;
   logic                  gnt, gnt_nxt;
   logic                  wr_lat, wr_lat_nxt;
   logic                  pick;
   logic [1:0]            ack, ack_nxt;
   logic                  busy, busy_nxt;
   logic                  en, en_nxt, rd, rd_nxt, wt, wt_nxt, oe, oe_nxt;
   logic [ADDR_WIDTH-1:0] addr, addr_nxt;
   logic [DATA_WIDTH-1:0] dout, dout_nxt, rdata, rdata_nxt;
`ifdef ARB_ROUND_ROBIN_EN
   logic                  last_gnt, last_gnt_nxt;
`endif

   // A lone requester always wins; only a tie consults the arbitration policy.
   always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
      if (bus.req == 2'b11) pick = ~last_gnt;
      else                  pick = ~bus.req[0];
`else
      pick = ~bus.req[0];
`endif
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      gnt_nxt    = gnt;
      wr_lat_nxt = wr_lat;
      ack_nxt    = 2'b00;
      en_nxt     = en;
      rd_nxt     = rd;
      wt_nxt     = wt;
      oe_nxt     = oe;
      addr_nxt   = addr;
      dout_nxt   = dout;
      rdata_nxt  = rdata;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_nxt = last_gnt;
`endif
      case (state)
         IDLE: begin
            en_nxt = 1'b0;
            rd_nxt = 1'b0;
            wt_nxt = 1'b0;
            oe_nxt = 1'b0;
            if (bus.req != 2'b00) begin
               gnt_nxt    = pick;
               wr_lat_nxt = bus.wr[pick];
               addr_nxt   = pick ? bus.addr1 : bus.addr0;
               dout_nxt   = pick ? bus.wdata1 : bus.wdata0;
               state_nxt  = SETUP;
`ifdef ARB_ROUND_ROBIN_EN
               last_gnt_nxt = pick;
`endif
            end
         end
         SETUP: begin
            en_nxt    = 1'b1;
            rd_nxt    = ~wr_lat;
            wt_nxt    = wr_lat;
            oe_nxt    = wr_lat;
            cnt_nxt   = CNT_LOAD;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else begin
               if (!wr_lat) rdata_nxt = bus.sram_data_in;
               state_nxt = DONE;
            end
         end
         DONE: begin
            // Output enable is kept for one more cycle to give the SRAM data hold time.
            en_nxt       = 1'b0;
            rd_nxt       = 1'b0;
            wt_nxt       = 1'b0;
            oe_nxt       = wr_lat;
            ack_nxt[gnt] = 1'b1;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         gnt    <= 1'b0;
         wr_lat <= 1'b0;
         ack    <= '0;
         busy   <= 1'b0;
         en     <= 1'b0;
         rd     <= 1'b0;
         wt     <= 1'b0;
         oe     <= 1'b0;
         addr   <= '0;
         dout   <= '0;
         rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_gnt <= 1'b1;
`endif
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         gnt    <= gnt_nxt;
         wr_lat <= wr_lat_nxt;
         ack    <= ack_nxt;
         busy   <= busy_nxt;
         en     <= en_nxt;
         rd     <= rd_nxt;
         wt     <= wt_nxt;
         oe     <= oe_nxt;
         addr   <= addr_nxt;
         dout   <= dout_nxt;
         rdata  <= rdata_nxt;
`ifdef ARB_ROUND_ROBIN_EN
         last_gnt <= last_gnt_nxt;
`endif
      end
   end

   assign bus.ack           = ack;
   assign bus.rdata         = rdata;
   assign bus.busy          = busy;
   assign bus.sram_address  = addr;
   assign bus.sram_enable   = en;
   assign bus.sram_read     = rd;
   assign bus.sram_write    = wt;
   assign bus.sram_data_out = dout;
   assign bus.sram_data_oe  = oe;
endmodule
